// File: rtl/frame_uart_tx_if.sv
// Signal bundle between a frame source/RAM side and the frame UART transmitter.
// The master side requests frames and serves RAM reads; the slave side is the
// transmitter itself.
interface frame_uart_tx_if;
  logic        start_in;
  logic [16:0] ram_addr_out;
  logic [6:0]  ram_data_in;
  logic        uart_tx_out;
  logic        busy_out;
  logic        done_out;

  modport master (
    output start_in,
    output ram_data_in,
    input  ram_addr_out,
    input  uart_tx_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  start_in,
    input  ram_data_in,
    output ram_addr_out,
    output uart_tx_out,
    output busy_out,
    output done_out
  );
endinterface

// File: rtl/frame_uart_tx.sv
// Streams one frame of 7-bit pixels out of a BRAM over an 8N1 UART line.
// Each frame is preceded by a 0xFF marker byte; pixel bytes always have MSB 0,
// so the marker cannot appear inside pixel data. RAM_LATENCY must be >= 1.
module frame_uart_tx #(
  parameter int BAUD_DIV    = 564,
  parameter int FRAME_W     = 240,
  parameter int FRAME_H     = 320,
  parameter int RAM_LATENCY = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  frame_uart_tx_if.slave  bus
);

  localparam int          NPIX      = FRAME_W * FRAME_H;
  localparam logic [16:0] LAST_PIX  = 17'(NPIX - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] WAIT_LAST = 16'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] pix_q, pix_d;      // index of the pixel being fetched/sent
  logic [15:0] timer_q, timer_d;  // bit timer; also paces the RAM wait
  logic [3:0]  bit_q, bit_d;      // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]  shift_q, shift_d;  // bit 0 is the data bit currently on the line
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        byte_end;

  // Next-state logic: frame sequencing, bit timing and shifter control.
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    bit_end  = (timer_q == BIT_LAST);
    byte_end = bit_end && (bit_q == 4'd9);

    unique case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d = SYNC;
          pix_d   = '0;
          timer_d = '0;
          bit_d   = '0;
          shift_d = 8'hFF;
        end
      end
      SYNC, SEND: begin
        if (bit_end) begin
          timer_d = '0;
          bit_d   = bit_q + 4'd1;
          // Advance to the next data bit only after a data bit has been held.
          if (bit_q >= 4'd1 && bit_q <= 4'd8) begin
            shift_d = {1'b0, shift_q[7:1]};
          end
          if (byte_end) begin
            bit_d = '0;
            if (state_q == SEND) begin
              pix_d   = pix_q + 17'd1;
              state_d = (pix_q == LAST_PIX) ? DONE : FETCH;
            end else begin
              state_d = FETCH;
            end
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      FETCH: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (timer_q == WAIT_LAST) begin
          state_d = SEND;
          timer_d = '0;
          bit_d   = '0;
          shift_d = {1'b0, bus.ram_data_in};
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level for the coming cycle, so the output comes straight off a flop.
    tx_d = 1'b1;
    if (state_d == SYNC || state_d == SEND) begin
      if (bit_d == 4'd0) begin
        tx_d = 1'b0;
      end else if (bit_d <= 4'd8) begin
        tx_d = shift_d[0];
      end
    end
  end

  // State and datapath registers; reset drops the line high immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pix_q   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Status and RAM address decoded from registered state; address is only
  // presented while a pixel is being fetched.
  always_comb begin
    bus.uart_tx_out  = tx_q;
    bus.busy_out     = (state_q != IDLE);
    bus.done_out     = (state_q == DONE);
    bus.ram_addr_out = (state_q == FETCH || state_q == WAIT) ? pix_q : 17'd0;
  end

endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx with a small frame and a pipelined RAM model.
module tb_frame_uart_tx;

  localparam int BD       = 4;
  localparam int FW       = 2;
  localparam int FH       = 2;
  localparam int RL       = 2;
  localparam int NPIX     = FW * FH;
  localparam int BYTE_CYC = 10 * BD;
  localparam int GAP      = 1 + RL;
  localparam int BUSY_LEN = (NPIX + 1) * BYTE_CYC + NPIX * GAP + 1;
  localparam int CAP      = BUSY_LEN + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  frame_uart_tx_if bus ();

  frame_uart_tx #(
    .BAUD_DIV   (BD),
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .RAM_LATENCY(RL)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: contents in mem, RL-cycle read pipeline.
  logic [6:0] mem  [NPIX];
  logic [6:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= (bus.ram_addr_out < 17'(NPIX)) ? mem[bus.ram_addr_out[1:0]] : 7'd0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_data_in = pipe[RL-1];

  // Captured DUT outputs per cycle (cycle 0 = the start pulse cycle).
  logic        cap_tx   [CAP+1];
  logic        cap_busy [CAP+1];
  logic        cap_done [CAP+1];
  logic [16:0] cap_addr [CAP+1];
  // Expected waveform built from the byte list.
  logic        exp_tx   [CAP+1];
  logic        exp_busy [CAP+1];
  logic        exp_done [CAP+1];

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic record(input int c);
    cap_tx[c]   = bus.uart_tx_out;
    cap_busy[c] = bus.busy_out;
    cap_done[c] = bus.done_out;
    cap_addr[c] = bus.ram_addr_out;
  endtask

  // Pulse start, then capture up to stop_cyc; optionally pulse start again.
  task automatic run_capture(input int stop_cyc, input int restart_cyc);
    @(posedge clk);
    #1 bus.start_in = 1'b1;
    @(negedge clk);
    record(0);
    @(posedge clk);
    #1 bus.start_in = 1'b0;
    for (int c = 1; c <= stop_cyc; c++) begin
      @(negedge clk);
      record(c);
      bus.start_in = (c == restart_cyc);
    end
    bus.start_in = 1'b0;
  endtask

  // Ideal line: 0xFF, then each pixel byte, GAP idle cycles between bytes,
  // every bit BD cycles, followed by a single done cycle.
  task automatic build_expected();
    int         p;
    logic [7:0] b;
    for (int c = 0; c <= CAP; c++) begin
      exp_tx[c] = 1'b1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
    end
    p = 1;
    for (int k = 0; k <= NPIX; k++) begin
      b = (k == 0) ? 8'hFF : {1'b0, mem[k-1]};
      if (k > 0) begin
        for (int g = 0; g < GAP; g++) begin exp_busy[p] = 1'b1; p++; end
      end
      for (int j = 0; j < 10; j++) begin
        for (int t = 0; t < BD; t++) begin
          exp_busy[p] = 1'b1;
          exp_tx[p]   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
          p++;
        end
      end
    end
    exp_busy[p] = 1'b1;
    exp_done[p] = 1'b1;
  endtask

  task automatic check_frame(input string tag);
    int         bad_tx, bad_busy, bad_done, nbusy, ndone, c;
    logic [7:0] dec [$];
    logic       stp [$];
    logic [7:0] b;
    build_expected();
    bad_tx = -1; bad_busy = -1; bad_done = -1; nbusy = 0; ndone = 0;
    for (int i = 0; i <= CAP; i++) begin
      if (cap_tx[i]   !== exp_tx[i]   && bad_tx   < 0) bad_tx   = i;
      if (cap_busy[i] !== exp_busy[i] && bad_busy < 0) bad_busy = i;
      if (cap_done[i] !== exp_done[i] && bad_done < 0) bad_done = i;
      nbusy += int'(cap_busy[i]);
      ndone += int'(cap_done[i]);
    end
    check({tag, "_tx_first_bad_cycle"},   bad_tx,   -1);
    check({tag, "_busy_first_bad_cycle"}, bad_busy, -1);
    check({tag, "_done_first_bad_cycle"}, bad_done, -1);
    check({tag, "_busy_cycles"}, nbusy, BUSY_LEN);
    check({tag, "_done_pulses"}, ndone, 1);
    check({tag, "_busy_c0"}, int'(cap_busy[0]), 0);
    check({tag, "_busy_c1"}, int'(cap_busy[1]), 1);

    // Independent UART decode: mid-bit sampling after each falling edge.
    c = 1;
    while (c <= CAP - BYTE_CYC) begin
      if (cap_tx[c] === 1'b0 && cap_tx[c-1] === 1'b1) begin
        for (int j = 0; j < 8; j++) b[j] = cap_tx[c + BD*(j+1) + BD/2];
        dec.push_back(b);
        stp.push_back(cap_tx[c + 9*BD + BD/2]);
        c += BYTE_CYC;
      end else begin
        c++;
      end
    end
    check({tag, "_byte_count"}, dec.size(), NPIX + 1);
    for (int k = 0; k <= NPIX; k++) begin
      b = (k == 0) ? 8'hFF : {1'b0, mem[k-1]};
      check($sformatf("%s_byte%0d", tag, k), (k < dec.size()) ? int'(dec[k]) : -1, int'(b));
      check($sformatf("%s_stop%0d", tag, k), (k < stp.size()) ? int'(stp[k]) : -1, 1);
    end

    // Address presented from FETCH through the capture cycle.
    for (int k = 0; k < NPIX; k++) begin
      for (int d = 0; d <= RL; d++) begin
        check($sformatf("%s_addr_px%0d_d%0d", tag, k, d),
              int'(cap_addr[1 + BYTE_CYC + k*(BYTE_CYC + GAP) + d]), k);
      end
    end
    check({tag, "_addr_c0"},   int'(cap_addr[0]),   0);
    check({tag, "_addr_tail"}, int'(cap_addr[CAP]), 0);
  endtask

  initial begin
    bus.start_in = 1'b0;
    for (int k = 0; k < NPIX; k++) mem[k] = 7'(k + 16);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",   int'(bus.uart_tx_out),  1);
    check("rst_busy", int'(bus.busy_out),     0);
    check("rst_done", int'(bus.done_out),     0);
    check("rst_addr", int'(bus.ram_addr_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", int'(bus.busy_out),    0);
    check("idle_tx",   int'(bus.uart_tx_out), 1);

    // Basic frame, addr+0x10 data
    run_capture(CAP, -1);
    check_frame("A_basic");

    // Start pulsed during byte 2 and during the done cycle: both ignored
    run_capture(CAP, 100);
    check_frame("B_start_busy");
    run_capture(CAP, BUSY_LEN);
    check_frame("G_start_done");

    // Random pixel data
    for (int k = 0; k < NPIX; k++) mem[k] = 7'($urandom_range(0, 127));
    run_capture(CAP, -1);
    check_frame("C_rand");

    // All-ones pixels: MSB of every byte must still be 0
    for (int k = 0; k < NPIX; k++) mem[k] = 7'h7F;
    run_capture(CAP, -1);
    check_frame("D_7f");

    // Reset during data bit 0 of pixel byte 0x10 (line low at that point)
    for (int k = 0; k < NPIX; k++) mem[k] = 7'(k + 16);
    build_expected();
    run_capture(50, -1);
    check("E_pre_tx",   int'(cap_tx[50]),   int'(exp_tx[50]));
    check("E_pre_busy", int'(cap_busy[50]), 1);
    rst = 1'b1;
    #1;
    check("E_rst_tx",   int'(bus.uart_tx_out),  1);
    check("E_rst_busy", int'(bus.busy_out),     0);
    check("E_rst_done", int'(bus.done_out),     0);
    check("E_rst_addr", int'(bus.ram_addr_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("E_post_busy", int'(bus.busy_out),    0);
    check("E_post_tx",   int'(bus.uart_tx_out), 1);
    run_capture(CAP, -1);
    check_frame("E_after_rst");

    // Reset while the address of pixel 2 is on the bus
    run_capture(1 + BYTE_CYC + 2*(BYTE_CYC + GAP) + 1, -1);
    check("F_pre_addr", int'(cap_addr[1 + BYTE_CYC + 2*(BYTE_CYC + GAP) + 1]), 2);
    rst = 1'b1;
    #1;
    check("F_rst_addr", int'(bus.ram_addr_out), 0);
    check("F_rst_busy", int'(bus.busy_out),     0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NPIX; k++) mem[k] = 7'($urandom_range(0, 127));
    run_capture(CAP, -1);
    check_frame("F_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_uart_tx.md
FRAME_UART_TX -- requirements
Module: frame_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 564, clock cycles per UART bit (65 MHz / 115200).
REQ-002 Parameter FRAME_W, default 240, pixels per row.
REQ-003 Parameter FRAME_H, default 320, rows per frame.
REQ-004 Parameter RAM_LATENCY, default 2, cycles from ram_addr_out change to valid ram_data_in.
REQ-005 clk_in  input  1  system clock (65 MHz); the only clock.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 start_in  input  1  single-cycle request to transmit one frame.
REQ-008 ram_addr_out  output  17  read address into the 7-bit frame BRAM, row-major (y*FRAME_W + x).
REQ-009 ram_data_in  input  7  pixel read from the frame BRAM.
REQ-010 uart_tx_out  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 busy_out  output  1  high while a frame transfer is in progress.
REQ-012 done_out  output  1  single-cycle pulse when the last stop bit completes.

Function
REQ-013 States SHALL be IDLE, SYNC, FETCH, WAIT, SEND, DONE.
REQ-014 IDLE: uart_tx_out=1 and busy_out=0; start_in=1 SHALL move to SYNC on the next edge and clear the pixel counter to 0.
REQ-015 SYNC SHALL load byte 0xFF into the shifter and transmit it; pixel bytes always have MSB 0, so 0xFF is a unique frame marker.
REQ-016 After any byte completes with pixels remaining, the block SHALL enter FETCH, drive ram_addr_out = pixel counter, and stay one cycle.
REQ-017 WAIT SHALL last RAM_LATENCY cycles, then capture {1'b0, ram_data_in} into the shifter and enter SEND.
REQ-018 SEND SHALL transmit the start bit (0), data bits 0..7, then the stop bit (1), each held exactly BAUD_DIV cycles: 10*BAUD_DIV cycles per byte.
REQ-019 The bit timer SHALL count 0..BAUD_DIV-1 and wrap; the bit index SHALL count 0..9.
REQ-020 The pixel counter SHALL increment by 1 at the end of each pixel byte; after pixel FRAME_W*FRAME_H-1 is sent, the block SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done_out=1, then return to IDLE; done_out SHALL be 0 in every other state.
REQ-022 busy_out SHALL be 1 in SYNC, FETCH, WAIT, SEND and DONE.
REQ-023 start_in SHALL be ignored whenever busy_out=1, including in the DONE cycle.
REQ-024 uart_tx_out SHALL be 1 in IDLE, FETCH, WAIT and DONE, so the inter-byte gap is idle-high for 1+RAM_LATENCY cycles.
REQ-025 uart_tx_out SHALL be registered: glitch-free, with no combinational path from any input.
REQ-026 ram_addr_out SHALL hold its value from FETCH through the WAIT capture cycle; it is 0 outside a transfer.
REQ-027 The counter width SHALL be 17 bits; FRAME_W*FRAME_H up to 131072 SHALL be supported without wrap.

Reset
REQ-028 rst_in=1 SHALL immediately force the following, regardless of clock: state=IDLE, uart_tx_out=1, busy_out=0, done_out=0, ram_addr_out=0, and pixel counter, bit timer, bit index and shifter all 0.
REQ-029 Reset asserted mid-byte SHALL abort the transfer with no partial stop bit; the line returns high at once.
REQ-030 After reset release, the block SHALL remain in IDLE until a new start_in.

Verification (BAUD_DIV=4, FRAME_W=2, FRAME_H=2, RAM_LATENCY=2, RAM model returns addr+0x10)
REQ-031 Frame sequence: start_in pulse at cycle 0. Required: busy_out=1 from cycle 1; line decodes bytes FF,10,11,12,13; done_out pulses once; then IDLE with line high.
REQ-032 Timing: the start bit of 0xFF spans exactly 4 cycles. The gap between consecutive bytes is exactly 3 high cycles. Total busy time is 5*40 + 4*3 + 1 cycles.
REQ-033 Start while busy: pulse start_in again during byte 2. Required: no restart; the byte stream and done_out timing are identical to REQ-031.
REQ-034 Reset mid-operation: assert rst_in during a data bit of pixel byte 1. Required: uart_tx_out=1, busy_out=0 and ram_addr_out=0 before the next clock edge. A subsequent start_in resends from 0xFF and pixel 0.
REQ-035 Addressing: check ram_addr_out in the FETCH cycles. Required: sequence 0,1,2,3, each held stable through its capture cycle.
REQ-036 Data MSB: the RAM model returns 0x7F. Required: the transmitted byte is 0x7F and bit 7 is always 0.
